// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: valid/ready byte stream leaving the receiver FIFO, plus the FIFO fill level.
interface uart_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_ready;
    logic [CW-1:0] fifo_count;

    modport master (output m_valid, output m_data, output fifo_count, input m_ready);
    modport slave  (input m_valid, input m_data, input fifo_count, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver (8N1; 8E1 when UART_RX_PARITY_EN is defined)
// feeding a first-word-fall-through byte FIFO with a valid/ready output stream.
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rxd,
    uart_rx_fifo_if.master m_if,
    output logic           frame_err,
    output logic           overrun
);
    localparam int unsigned TICK_DIV = CLK_HZ / (BAUD * 16);
    localparam int unsigned TW       = $clog2(TICK_DIV);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CW       = AW + 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitIdle} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;
`endif

    state_e        state;
    logic          rx_meta, rxs, rxs_prev;
    logic [TW-1:0] tick_cnt;
    logic          tick, start_edge, mid_bit, bit_end;
    logic [3:0]    s_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          samp7, samp8, maj;
    logic          stop_ok, push, pop, full, valid;
`ifdef UART_RX_PARITY_EN
    logic          par_err;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rxd;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign start_edge = (state == StIdle) && rxs_prev && !rxs;
    assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
    assign mid_bit    = tick && (s_cnt == 4'd9);
    assign bit_end    = tick && (s_cnt == 4'd15);
    assign maj        = (samp7 & samp8) | (samp7 & rxs) | (samp8 & rxs);

    // Restart the tick phase at the start edge so s=7..9 straddle the bit centre.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (start_edge || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign valid = (count != '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign pop   = valid && m_if.m_ready;
`ifdef UART_RX_PARITY_EN
    assign stop_ok = (state == StStop) && mid_bit && maj && !par_err;
`else
    assign stop_ok = (state == StStop) && mid_bit && maj;
`endif
    assign push  = stop_ok && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            s_cnt     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            samp7     <= 1'b1;
            samp8     <= 1'b1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (tick && s_cnt == 4'd7) samp7 <= rxs;
            if (tick && s_cnt == 4'd8) samp8 <= rxs;
            unique case (state)
                StIdle: begin
                    if (start_edge) begin
                        state   <= StStart;
                        s_cnt   <= '0;
                        bit_idx <= '0;
                    end
                end
                StStart: begin
                    if (tick) s_cnt <= s_cnt + 1'b1;
                    if (mid_bit && maj) state <= StIdle;
                    else if (bit_end) state <= StData;
                end
                StData: begin
                    if (tick) s_cnt <= s_cnt + 1'b1;
                    if (mid_bit) shreg <= {maj, shreg[7:1]};
                    if (bit_end) begin
                        bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (bit_idx == 3'd7) state <= StParity;
`else
                        if (bit_idx == 3'd7) state <= StStop;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick) s_cnt <= s_cnt + 1'b1;
                    if (mid_bit) par_err <= maj ^ (^shreg);
                    if (bit_end) state <= StStop;
                end
`endif
                StStop: begin
                    // Decide at mid-bit so a back-to-back start edge is not missed.
                    if (mid_bit) begin
                        if (!maj) begin
                            frame_err <= 1'b1;
                            s_cnt     <= '0;
                            state     <= StWaitIdle;
`ifdef UART_RX_PARITY_EN
                        end else if (par_err) begin
                            frame_err <= 1'b1;
                            state     <= StIdle;
`endif
                        end else begin
                            overrun <= !push;
                            state   <= StIdle;
                        end
                    end else if (tick) begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                StWaitIdle: begin
                    if (tick) begin
                        if (!rxs) s_cnt <= '0;
                        else if (s_cnt == 4'd15) state <= StIdle;
                        else s_cnt <= s_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign m_if.m_valid    = valid;
    assign m_if.m_data     = valid ? mem[rd_ptr] : 8'h00;
    assign m_if.fifo_count = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed and random UART frames checked against a queue model of the
// expected byte stream, error pulse counts and FIFO occupancy.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int unsigned CLK_HZ  = 1536000;
    localparam int unsigned BAUD    = 9600;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned BIT_CLK = CLK_HZ / BAUD;
    localparam int unsigned TICK    = CLK_HZ / (BAUD * 16);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic frame_err, overrun;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) m_if ();

    uart_rx_fifo #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .m_if     (m_if),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  got_q[$];
    int unsigned ferr_seen = 0, ovr_seen = 0, valid_cycles = 0, rise_cyc = 0;
    logic        prev_valid = 1'b0;
    always @(negedge clk) begin
        if (m_if.m_valid && m_if.m_ready) got_q.push_back(m_if.m_data);
        if (frame_err) ferr_seen++;
        if (overrun) ovr_seen++;
        if (m_if.m_valid) valid_cycles++;
        if (m_if.m_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = m_if.m_valid;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, observed %0d cycles required < 95000", cyc);
        $fatal(1);
    end

    int unsigned n_pass = 0, n_total = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_to(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        tick_to(BIT_CLK);
    endtask

    int unsigned frame_start = 0;
    task automatic send_frame(input logic [7:0] d, input logic stop);
        frame_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

    // Reference model: byte stream the consumer must see, FIFO occupancy, expected error pulses.
    logic [7:0]  exp_q[$];
    int unsigned occ = 0, exp_ferr = 0, exp_ovr = 0, chk_idx = 0;
    task automatic model_frame(input logic [7:0] d, input logic good, input logic pop_now);
        if (!good) exp_ferr++;
        else if (pop_now) exp_q.push_back(d);
        else if (occ < DEPTH) begin
            exp_q.push_back(d);
            occ++;
        end else exp_ovr++;
    endtask

    task automatic check_errs(input string tag);
        chk({tag, "_frame_err"}, ferr_seen, exp_ferr);
        chk({tag, "_overrun"}, ovr_seen, exp_ovr);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        chk_idx = exp_q.size();
        check_errs(tag);
    endtask

    task automatic drain();
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && m_if.fifo_count != 0; i++) tick_to(1);
        tick_to(2);
        occ = 0;
        chk("drain_empty", m_if.fifo_count, 0);
    endtask

    int unsigned lat = 0;
    int unsigned vc0;
    logic [7:0]  d;

    initial begin
        m_if.m_ready = 1'b0;
        tick_to(3);
        chk("rst_valid", m_if.m_valid, 0);
        chk("rst_data", m_if.m_data, 0);
        chk("rst_count", m_if.fifo_count, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick_to(20);

        // Single byte with consumer ready: one-cycle valid, shortly after stop mid-bit.
        m_if.m_ready = 1'b1;
        vc0 = valid_cycles;
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1, 1'b1);
        lat = rise_cyc - frame_start;
        tick_to(100);
        check_stream("a5");
        chk("a5_valid_cycles", valid_cycles - vc0, 1);
        chk("a5_latency_window",
            32'(lat >= 9 * BIT_CLK + 9 * TICK && lat <= 9 * BIT_CLK + 11 * TICK + 5), 1);
`ifdef UART_RX_PARITY_EN
        lat = lat + BIT_CLK - BIT_CLK;
`endif

        // Random burst held in the FIFO, then drained in order.
        m_if.m_ready = 1'b0;
        for (int i = 0; i < int'($urandom_range(3, 6)); i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1);
            model_frame(d, 1'b1, 1'b0);
        end
        tick_to(50);
        chk("rand_count", m_if.fifo_count, occ);
        chk("rand_head", m_if.m_data, exp_q[chk_idx]);
        drain();
        check_stream("rand");

        // Short low glitch on an idle line must be ignored.
        rxd = 1'b0;
        tick_to(40);
        rxd = 1'b1;
        tick_to(400);
        check_stream("glitch");
        chk("glitch_count", m_if.fifo_count, 0);
        d = 8'($urandom);
        send_frame(d, 1'b1);
        model_frame(d, 1'b1, 1'b1);
        tick_to(100);
        check_stream("post_glitch");

        // Stop bit held low: one frame_err, nothing stored, next frame fine.
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b1);
        rxd = 1'b1;
        tick_to(400);
        check_stream("ferr");
        chk("ferr_count", m_if.fifo_count, 0);
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1, 1'b1);
        tick_to(100);
        check_stream("post_ferr");

        // Nine bytes into an eight-entry FIFO with no consumer.
        m_if.m_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1'b1, 1'b0);
        end
        tick_to(50);
        chk("ovf_count", m_if.fifo_count, DEPTH);
        chk("ovf_head", m_if.m_data, 8'h01);
        check_errs("ovf");
        drain();
        check_stream("ovf_drain");

        // Full FIFO with a pop in the very cycle the ninth byte is pushed.
        m_if.m_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1);
            model_frame(d, 1'b1, 1'b0);
        end
        tick_to(50);
        chk("full_count", m_if.fifo_count, DEPTH);
        d = 8'($urandom);
        fork
            send_frame(d, 1'b1);
            begin
                tick_to(lat - 1);
                m_if.m_ready = 1'b1;
                tick_to(1);
                m_if.m_ready = 1'b0;
            end
        join
        model_frame(d, 1'b1, 1'b1);
        tick_to(20);
        chk("fullpop_count", m_if.fifo_count, DEPTH);
        check_errs("fullpop");
        drain();
        check_stream("fullpop_drain");

        // Reset in the middle of data bit 4 with two bytes queued.
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1);
            model_frame(d, 1'b1, 1'b0);
        end
        tick_to(50);
        chk("prerst_count", m_if.fifo_count, 2);
        d = 8'($urandom);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rxd = d[4];
        tick_to(BIT_CLK / 2);
        rst = 1'b1;
        #1;
        chk("midrst_valid", m_if.m_valid, 0);
        chk("midrst_count", m_if.fifo_count, 0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        occ = 0;
        rxd = 1'b1;
        tick_to(3);
        rst = 1'b0;
        tick_to(400);
        chk("postrst_count", m_if.fifo_count, 0);
        m_if.m_ready = 1'b1;
        send_frame(8'h7E, 1'b1);
        model_frame(8'h7E, 1'b1, 1'b1);
        tick_to(100);
        check_stream("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
